// File: rtl/cpu_branch_predictor_if.sv
// ----------------------------------------------------------------------------
// cpu_branch_predictor_if
//   Bundles the fetch-side lookup, the execute-side resolution and the
//   statistics signals of the branch predictor into one connection.
//
//   Fetch   : f_pc -> f_pred_taken, f_pred_target
//   Execute : e_valid, e_pc, e_branch, e_jump, e_taken, e_target,
//             e_pred_taken, e_pred_target -> e_mispredict
//   Stats   : stat_clear -> stat_branches, stat_mispredicts
//
//   master : the pipeline side (drives PCs and resolutions)
//   slave  : the predictor side
// ----------------------------------------------------------------------------
interface cpu_branch_predictor_if;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;

    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_branch;
    logic        e_jump;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_pred_taken;
    logic [31:0] e_pred_target;
    logic        e_mispredict;

    logic        stat_clear;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output f_pc,
        input  f_pred_taken, f_pred_target,
        output e_valid, e_pc, e_branch, e_jump, e_taken, e_target,
               e_pred_taken, e_pred_target,
        input  e_mispredict,
        output stat_clear,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  f_pc,
        output f_pred_taken, f_pred_target,
        input  e_valid, e_pc, e_branch, e_jump, e_taken, e_target,
               e_pred_taken, e_pred_target,
        output e_mispredict,
        input  stat_clear,
        output stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/cpu_branch_predictor.sv
// ----------------------------------------------------------------------------
// cpu_branch_predictor
//   Direct-mapped dynamic branch predictor: per-entry valid/tag/target plus a
//   CTR_BITS saturating counter. Fetch lookup is combinational; training from
//   execute-stage resolution is written on the rising clock edge. Also flags
//   execute-stage mispredictions and keeps saturating statistics counters.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - asynchronous, active-high reset
//     bp   - cpu_branch_predictor_if.slave (fetch / execute / statistics)
//
//   Parameters:
//     ENTRIES  - table entries, power of two, 2..1024
//     CTR_BITS - saturating counter width, 1..4
// ----------------------------------------------------------------------------
module cpu_branch_predictor #(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_branch_predictor_if.slave bp
);

    localparam int unsigned IB     = $clog2(ENTRIES);
    localparam int unsigned TAG_W  = 30 - IB;
    localparam int unsigned WT_INT = 1 << (CTR_BITS - 1);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(WT_INT);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(WT_INT - 1);

    // Prediction table
    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

    logic [31:0]         r_stat_branches;
    logic [31:0]         r_stat_mispredicts;

    // Fetch-side lookup
    logic [IB-1:0]       w_f_idx;
    logic [TAG_W-1:0]    w_f_tag;
    logic                w_f_hit;
    logic                w_f_taken;

    // Execute-side update
    logic [IB-1:0]       w_e_idx;
    logic [TAG_W-1:0]    w_e_tag;
    logic                w_e_hit;
    logic                w_active;
    logic                w_eff_taken;
    logic                w_wr_en;
    logic [CTR_BITS-1:0] w_wr_ctr;
    logic [31:0]         w_wr_target;
    logic                w_mispredict;

    // Byte-offset PC bits carry no information for a word-aligned table.
    logic                w_unused;
    assign w_unused = &{1'b0, bp.f_pc[1:0], bp.e_pc[1:0]};

    // ------------------------------------------------------------------------
    // Lookup (zero latency, reads pre-update state: no write bypass)
    // ------------------------------------------------------------------------
    assign w_f_idx   = bp.f_pc[IB+1:2];
    assign w_f_tag   = bp.f_pc[31:IB+2];
    assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken = w_f_hit && r_ctr[w_f_idx][CTR_BITS-1];

    assign bp.f_pred_taken  = w_f_taken;
    assign bp.f_pred_target = w_f_taken ? r_target[w_f_idx] : '0;

    // ------------------------------------------------------------------------
    // Update decision
    // ------------------------------------------------------------------------
    assign w_e_idx  = bp.e_pc[IB+1:2];
    assign w_e_tag  = bp.e_pc[31:IB+2];
    assign w_e_hit  = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    assign w_active = bp.e_valid && (bp.e_branch || bp.e_jump);

    always_comb begin
        w_eff_taken = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_ctr    = r_ctr[w_e_idx];
        w_wr_target = r_target[w_e_idx];
        if (w_active) begin
            if (bp.e_jump) begin
                // Jumps win over a simultaneous branch flag: always taken.
                w_eff_taken = 1'b1;
                w_wr_en     = 1'b1;
                w_wr_ctr    = CTR_MAX;
                w_wr_target = bp.e_target;
            end else begin
                w_eff_taken = bp.e_taken;
                if (w_e_hit) begin
                    w_wr_en = 1'b1;
                    if (bp.e_taken) begin
                        w_wr_target = bp.e_target;
                        if (r_ctr[w_e_idx] != CTR_MAX)
                            w_wr_ctr = r_ctr[w_e_idx] + 1'b1;
                    end else if (r_ctr[w_e_idx] != '0) begin
                        w_wr_ctr = r_ctr[w_e_idx] - 1'b1;
                    end
                end else if (bp.e_taken) begin
                    // Miss (including alias): allocate as weakly taken.
                    w_wr_en     = 1'b1;
                    w_wr_ctr    = CTR_WT;
                    w_wr_target = bp.e_target;
                end
            end
        end
    end

    assign w_mispredict = w_active &&
                          ((w_eff_taken != bp.e_pred_taken) ||
                           (w_eff_taken && (bp.e_target != bp.e_pred_target)));
    assign bp.e_mispredict = w_mispredict;

    // ------------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[IB'(i)]  <= 1'b0;
                r_tag[IB'(i)]    <= '0;
                r_target[IB'(i)] <= '0;
                r_ctr[IB'(i)]    <= CTR_WNT;
            end
        end else if (w_wr_en) begin
            r_valid[w_e_idx]  <= 1'b1;
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= w_wr_target;
            r_ctr[w_e_idx]    <= w_wr_ctr;
        end
    end

    // ------------------------------------------------------------------------
    // Statistics (saturating; clear wins over a same-cycle increment)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (bp.stat_clear) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_active && (r_stat_branches != '1))
                r_stat_branches <= r_stat_branches + 32'd1;
            if (w_mispredict && (r_stat_mispredicts != '1))
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign bp.stat_branches    = r_stat_branches;
    assign bp.stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_cpu_branch_predictor
//   Directed testbench for cpu_branch_predictor (ENTRIES=64, CTR_BITS=2).
//   With 64 entries the index is pc[7:2] and the tag pc[31:8], so PCs
//   0x100/0x200/0x300/0x500 all share index 0 with different tags.
// ----------------------------------------------------------------------------
module tb_cpu_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    cpu_branch_predictor_if bp_if ();

    cpu_branch_predictor #(
        .ENTRIES  (64),
        .CTR_BITS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle();
        bp_if.e_valid       = 1'b0;
        bp_if.e_pc          = '0;
        bp_if.e_branch      = 1'b0;
        bp_if.e_jump        = 1'b0;
        bp_if.e_taken       = 1'b0;
        bp_if.e_target      = '0;
        bp_if.e_pred_taken  = 1'b0;
        bp_if.e_pred_target = '0;
        bp_if.stat_clear    = 1'b0;
    endtask

    // Advance one clock; leaves us 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt);
        bp_if.f_pc = pc;
        #1;
        check({tag, ".taken"},  32'(bp_if.f_pred_taken), 32'(tk));
        check({tag, ".target"}, bp_if.f_pred_target, tgt);
    endtask

    task automatic stats(input string tag, input logic [31:0] b,
                         input logic [31:0] m);
        check({tag, ".branches"},    bp_if.stat_branches,    b);
        check({tag, ".mispredicts"}, bp_if.stat_mispredicts, m);
    endtask

    task automatic drive(input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        bp_if.e_valid       = 1'b1;
        bp_if.e_pc          = pc;
        bp_if.e_branch      = br;
        bp_if.e_jump        = jmp;
        bp_if.e_taken       = tk;
        bp_if.e_target      = tgt;
        bp_if.e_pred_taken  = ptk;
        bp_if.e_pred_target = ptgt;
    endtask

    // One resolution: drive, check the combinational mispredict, clock it in.
    task automatic upd(input string tag, input logic [31:0] pc,
                       input logic br, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt, input logic mp);
        drive(pc, br, jmp, tk, tgt, ptk, ptgt);
        #1;
        check({tag, ".mp"}, 32'(bp_if.e_mispredict), 32'(mp));
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        bp_if.f_pc = '0;
        idle();
        tick();
        rst = 1'b0;

        // Reset state
        lookup("rst_100", 32'h100, 1'b0, 32'h0);
        lookup("rst_3fc", 32'h3fc, 1'b0, 32'h0);
        check("rst_mp_idle", 32'(bp_if.e_mispredict), 32'h0);
        stats("rst", 32'd0, 32'd0);

        // First taken branch allocates; same-cycle lookup sees old entry
        drive(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        lookup("nobypass", 32'h100, 1'b0, 32'h0);
        check("alloc.mp", 32'(bp_if.e_mispredict), 32'h1);
        tick();
        lookup("alloc", 32'h100, 1'b1, 32'h80);
        stats("alloc", 32'd1, 32'd1);

        // Counter walk 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2
        upd("nt1", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        lookup("nt1", 32'h100, 1'b0, 32'h0);
        upd("nt2", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup("nt2", 32'h100, 1'b0, 32'h0);
        upd("nt3", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup("nt3_sat0", 32'h100, 1'b0, 32'h0);
        upd("t1", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        lookup("t1", 32'h100, 1'b0, 32'h0);
        upd("t2", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        lookup("t2", 32'h100, 1'b1, 32'h80);
        upd("t3", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        upd("t4", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        upd("nt4", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        lookup("nt4_sat3", 32'h100, 1'b1, 32'h80);
        stats("walk", 32'd9, 32'd5);

        // Aliasing on index 0
        upd("jal", 32'h200, 1'b0, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0, 1'b1);
        lookup("jal_200", 32'h200, 1'b1, 32'h400);
        lookup("jal_100", 32'h100, 1'b0, 32'h0);
        upd("alias_nt", 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup("alias_nt_200", 32'h200, 1'b1, 32'h400);
        upd("alias_t", 32'h300, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
        lookup("alias_t_200", 32'h200, 1'b0, 32'h0);
        lookup("alias_t_300", 32'h300, 1'b1, 32'h10);
        upd("alias_weak", 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
        lookup("alias_weak", 32'h300, 1'b0, 32'h0);
        upd("jprio", 32'h500, 1'b1, 1'b1, 1'b0, 32'h44, 1'b0, 32'h0, 1'b1);
        lookup("jprio", 32'h500, 1'b1, 32'h44);
        stats("alias", 32'd14, 32'd9);

        // Target mispredict and ignored updates (index 1)
        upd("jal104", 32'h104, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b1);
        upd("tgt_mp", 32'h104, 1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1);
        lookup("tgt_mp", 32'h104, 1'b1, 32'h90);
        upd("tgt_ok", 32'h104, 1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 32'h90, 1'b0);
        drive(32'h104, 1'b1, 1'b0, 1'b1, 32'h999, 1'b0, 32'h0);
        bp_if.e_valid = 1'b0;
        #1;
        check("novalid.mp", 32'(bp_if.e_mispredict), 32'h0);
        tick();
        drive(32'h104, 1'b0, 1'b0, 1'b1, 32'h999, 1'b0, 32'h0);
        #1;
        check("nonbranch.mp", 32'(bp_if.e_mispredict), 32'h0);
        tick();
        lookup("novalid", 32'h104, 1'b1, 32'h90);
        stats("novalid", 32'd17, 32'd11);

        // Statistics saturation
        force dut.r_stat_branches = 32'hFFFF_FFFE;
        #1;
        release dut.r_stat_branches;
        stats("preset", 32'hFFFF_FFFE, 32'd11);
        upd("sat1", 32'h800, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        stats("sat1", 32'hFFFF_FFFF, 32'd11);
        upd("sat2", 32'h800, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        stats("sat2", 32'hFFFF_FFFF, 32'd11);

        // Clear wins over a same-cycle increment
        bp_if.stat_clear = 1'b1;
        upd("clr", 32'h104, 1'b1, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0, 1'b1);
        stats("clr", 32'd0, 32'd0);
        upd("postclr", 32'h104, 1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 32'h90, 1'b0);
        stats("postclr", 32'd1, 32'd0);

        // Asynchronous reset between clock edges
        lookup("prerst", 32'h104, 1'b1, 32'h90);
        rst = 1'b1;
        lookup("midrst", 32'h104, 1'b0, 32'h0);
        stats("midrst", 32'd0, 32'd0);
        rst = 1'b0;
        upd("afterrst", 32'h104, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
        lookup("afterrst_104", 32'h104, 1'b1, 32'h20);
        lookup("afterrst_500", 32'h500, 1'b0, 32'h0);
        stats("afterrst", 32'd1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
